// File: rtl/useful_ctr_ctrl.sv
// Read-modify-write update controller for the 128x3b saturating counter table.
// Also schedules periodic and requested aging pulses on the table's Atten input.
module useful_ctr_ctrl #(
    parameter int AGE_PERIOD = 1024,
    parameter int AGE_W      = 10
) (
    input  logic       Clk,
    input  logic       Rest,
    input  logic       UpdValid,
    output logic       UpdReady,
    input  logic [6:0] UpdAddr,
    input  logic [1:0] UpdOp,
    input  logic [2:0] UpdVal,
    input  logic       AgeReq,
    output logic       RspValid,
    output logic [6:0] RspAddr,
    output logic [2:0] RspOld,
    output logic [2:0] RspNew,
    output logic       CtrAtten,
    output logic [6:0] CtrAddr,
    output logic       CtrWen,
    output logic [2:0] CtrDin,
    input  logic [2:0] CtrDout,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        AGE
    } state_e;

    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);

    state_e           state_q, state_d;
    logic [AGE_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic [6:0]       addr_q, addr_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       val_q, val_d;

    logic             wrap;
    logic             age_set;
    logic             ready_int;
    logic [2:0]       new_val;

    assign wrap    = (timer_q == AGE_LAST);
    assign timer_d = wrap ? '0 : timer_q + 1'b1;
    assign age_set = wrap | AgeReq;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q | age_set;
        addr_d    = addr_q;
        op_d      = op_q;
        val_d     = val_q;
        ready_int = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A request arriving this cycle still wins over the update.
                if (pend_q | age_set) begin
                    state_d = AGE;
                    pend_d  = 1'b0;
                end else begin
                    ready_int = 1'b1;
                    if (UpdValid) begin
                        addr_d  = UpdAddr;
                        op_d    = UpdOp;
                        val_d   = UpdVal;
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = WRITE;
            WRITE: state_d = IDLE;
            AGE: begin
                state_d = IDLE;
                pend_d  = age_set;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        new_val = CtrDout;
        unique case (op_q)
            2'b00: new_val = (CtrDout == 3'd7) ? 3'd7 : CtrDout + 3'd1;
            2'b01: new_val = (CtrDout == 3'd0) ? 3'd0 : CtrDout - 3'd1;
            2'b10: new_val = val_q;
            2'b11: new_val = CtrDout;
            default: new_val = CtrDout;
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            op_q    <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            val_q   <= val_d;
        end
    end

    assign UpdReady = ready_int & Rest;
    assign CtrAtten = (state_q == AGE);
    assign CtrWen   = (state_q == WRITE);
    assign CtrAddr  = (state_q == READ || state_q == WRITE) ? addr_q : '0;
    assign CtrDin   = CtrWen ? new_val : '0;
    assign RspValid = CtrWen;
    assign RspAddr  = CtrWen ? addr_q : '0;
    assign RspOld   = CtrWen ? CtrDout : '0;
    assign RspNew   = CtrDin;
    assign Busy     = (state_q != IDLE) | pend_q;

endmodule

// File: tb/tb_useful_ctr_ctrl.sv
// Bench for useful_ctr_ctrl: directed vectors, corner sequences and a
// randomized run against a table-level reference model.
module tb_useful_ctr_ctrl;

    localparam int AGE_P = 1024;

    logic       Clk;
    logic       Rest;
    logic       UpdValid;
    logic       UpdReady;
    logic [6:0] UpdAddr;
    logic [1:0] UpdOp;
    logic [2:0] UpdVal;
    logic       AgeReq;
    logic       RspValid;
    logic [6:0] RspAddr;
    logic [2:0] RspOld;
    logic [2:0] RspNew;
    logic       CtrAtten;
    logic [6:0] CtrAddr;
    logic       CtrWen;
    logic [2:0] CtrDin;
    logic [2:0] CtrDout;
    logic       Busy;

    logic       u16_ready;
    logic       u16_rsp_valid;
    logic [6:0] u16_rsp_addr;
    logic [2:0] u16_rsp_old;
    logic [2:0] u16_rsp_new;
    logic       u16_atten;
    logic [6:0] u16_addr;
    logic       u16_wen;
    logic [2:0] u16_din;
    logic [2:0] u16_dout;
    logic       u16_busy;
    logic       u16_valid;
    logic       u16_age;

    useful_ctr_ctrl #(.AGE_PERIOD(AGE_P), .AGE_W(10)) dut (
        .Clk(Clk), .Rest(Rest),
        .UpdValid(UpdValid), .UpdReady(UpdReady),
        .UpdAddr(UpdAddr), .UpdOp(UpdOp), .UpdVal(UpdVal),
        .AgeReq(AgeReq),
        .RspValid(RspValid), .RspAddr(RspAddr),
        .RspOld(RspOld), .RspNew(RspNew),
        .CtrAtten(CtrAtten), .CtrAddr(CtrAddr), .CtrWen(CtrWen),
        .CtrDin(CtrDin), .CtrDout(CtrDout), .Busy(Busy)
    );

    useful_ctr_ctrl #(.AGE_PERIOD(16), .AGE_W(4)) dut16 (
        .Clk(Clk), .Rest(Rest),
        .UpdValid(u16_valid), .UpdReady(u16_ready),
        .UpdAddr(7'd0), .UpdOp(2'd0), .UpdVal(3'd0),
        .AgeReq(u16_age),
        .RspValid(u16_rsp_valid), .RspAddr(u16_rsp_addr),
        .RspOld(u16_rsp_old), .RspNew(u16_rsp_new),
        .CtrAtten(u16_atten), .CtrAddr(u16_addr), .CtrWen(u16_wen),
        .CtrDin(u16_din), .CtrDout(u16_dout), .Busy(u16_busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Behavioural counter tables: registered read, single port, global decrement.
    logic [2:0] mem   [128];
    logic [2:0] mem16 [128];
    logic [2:0] dout_r, dout16_r;
    logic       pre16_en;
    logic [6:0] pre16_addr;
    logic [2:0] pre16_val;

    assign CtrDout  = dout_r;
    assign u16_dout = dout16_r;

    always @(posedge Clk) begin
        if (!Rest) begin
            for (int i = 0; i < 128; i++) mem[i] <= 3'd0;
            dout_r <= 3'd0;
        end else begin
            if (CtrAtten) begin
                for (int i = 0; i < 128; i++)
                    mem[i] <= (mem[i] == 3'd0) ? 3'd0 : mem[i] - 3'd1;
            end else if (CtrWen) begin
                mem[CtrAddr] <= CtrDin;
            end
            dout_r <= mem[CtrAddr];
        end
    end

    always @(posedge Clk) begin
        if (!Rest) begin
            for (int i = 0; i < 128; i++) mem16[i] <= 3'd0;
            dout16_r <= 3'd0;
        end else if (pre16_en) begin
            mem16[pre16_addr] <= pre16_val;
        end else begin
            if (u16_atten) begin
                for (int i = 0; i < 128; i++)
                    mem16[i] <= (mem16[i] == 3'd0) ? 3'd0 : mem16[i] - 3'd1;
            end else if (u16_wen) begin
                mem16[u16_addr] <= u16_din;
            end
            dout16_r <= mem16[u16_addr];
        end
    end

    // Cycles since reset release, as seen at the falling edge.
    int ecnt;
    always @(posedge Clk or negedge Rest) begin
        if (!Rest) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    int errs;
    int checks;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, ecnt);
        end
    endtask

    function automatic logic [2:0] apply_op(input logic [1:0] op,
                                            input logic [2:0] old,
                                            input logic [2:0] v);
        int r;
        case (op)
            2'd0:    r = (old + 1 > 7) ? 7 : old + 1;
            2'd1:    r = (int'(old) - 1 < 0) ? 0 : int'(old) - 1;
            2'd2:    r = v;
            default: r = old;
        endcase
        return 3'(r);
    endfunction

    task automatic step(input bit v, input logic [1:0] op,
                        input logic [6:0] a, input logic [2:0] val,
                        input bit age);
        @(posedge Clk);
        #1;
        UpdValid = v;
        UpdOp    = op;
        UpdAddr  = a;
        UpdVal   = val;
        AgeReq   = age;
        @(negedge Clk);
    endtask

    task automatic do_upd(input logic [1:0] op, input logic [6:0] a,
                          input logic [2:0] v,
                          output logic [2:0] o, output logic [2:0] n,
                          output logic [6:0] ra, output int lat,
                          output bit ok);
        int t;
        ok  = 1'b0;
        o   = '0;
        n   = '0;
        ra  = '0;
        lat = 0;
        t   = 0;
        step(1'b1, op, a, v, 1'b0);
        while (!UpdReady && t < 10) begin
            step(1'b1, op, a, v, 1'b0);
            t++;
        end
        if (!UpdReady) begin
            step(1'b0, 2'd0, 7'd0, 3'd0, 1'b0);
            return;
        end
        step(1'b0, 2'd0, 7'd0, 3'd0, 1'b0);
        lat = 1;
        while (!RspValid && lat < 6) begin
            step(1'b0, 2'd0, 7'd0, 3'd0, 1'b0);
            lat++;
        end
        ok = RspValid;
        o  = RspOld;
        n  = RspNew;
        ra = RspAddr;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [6:0] addr;
        logic [2:0] val;
        logic [2:0] exp_old;
        logic [2:0] exp_new;
    } vec_t;

    typedef struct {
        logic [6:0] a;
        logic [1:0] op;
        logic [2:0] v;
        int         acc;
    } req_t;

    logic [2:0] mdl_mem [128];
    req_t       pq [$];
    bit         age_out;
    int         age_wait;

    task automatic rnd_iter(input bit rnd);
        req_t       r;
        logic [2:0] eo, en;
        @(posedge Clk);
        #1;
        if (rnd) begin
            UpdValid = 1'($urandom_range(0, 1));
            UpdOp    = 2'($urandom_range(0, 3));
            UpdAddr  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 3))
                                                    : 7'($urandom_range(124, 127));
            UpdVal   = 3'($urandom_range(0, 7));
            AgeReq   = ($urandom_range(0, 19) == 0);
        end else begin
            UpdValid = 1'b0;
            AgeReq   = 1'b0;
        end
        @(negedge Clk);
        if (CtrAtten) begin
            check("atten_justified", int'(age_out), 1);
            check("atten_not_mid_rmw", pq.size(), 0);
            age_out = 1'b0;
            for (int i = 0; i < 128; i++)
                mdl_mem[i] = (mdl_mem[i] == 3'd0) ? 3'd0 : mdl_mem[i] - 3'd1;
        end
        if (RspValid) begin
            if (pq.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                r  = pq.pop_front();
                eo = mdl_mem[r.a];
                en = apply_op(r.op, eo, r.v);
                check("rnd_latency", ecnt - r.acc, 2);
                check("rnd_addr", int'(RspAddr), int'(r.a));
                check("rnd_old", int'(RspOld), int'(eo));
                check("rnd_new", int'(RspNew), int'(en));
                mdl_mem[r.a] = en;
            end
        end else if (pq.size() > 0 && ecnt - pq[0].acc >= 2) begin
            check("rsp_timeout", ecnt - pq[0].acc, 1);
            void'(pq.pop_front());
        end
        if (AgeReq) check("ready_blocked_by_age", int'(UpdReady), 0);
        if (AgeReq || (ecnt % AGE_P) == AGE_P - 1) begin
            if (!age_out) begin
                age_out  = 1'b1;
                age_wait = 0;
            end
        end
        if (age_out) begin
            age_wait++;
            if (age_wait > 4) begin
                check("atten_latency", age_wait, 4);
                age_out = 1'b0;
            end
        end
        if (UpdValid && UpdReady)
            pq.push_back('{a: UpdAddr, op: UpdOp, v: UpdVal, acc: ecnt});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [12];
        logic [2:0] o, n;
        logic [6:0] ra;
        int         lat;
        bit         ok;
        int         pulses, first_i, mism;

        errs       = 0;
        checks     = 0;
        Rest       = 1'b0;
        UpdValid   = 1'b0;
        UpdAddr    = '0;
        UpdOp      = '0;
        UpdVal     = '0;
        AgeReq     = 1'b0;
        u16_valid  = 1'b0;
        u16_age    = 1'b0;
        pre16_en   = 1'b0;
        pre16_addr = '0;
        pre16_val  = '0;
        age_out    = 1'b0;
        age_wait   = 0;

        vecs[0]  = '{2'd0, 7'd5,   3'd0, 3'd0, 3'd1};
        vecs[1]  = '{2'd0, 7'd5,   3'd0, 3'd1, 3'd2};
        vecs[2]  = '{2'd0, 7'd5,   3'd0, 3'd2, 3'd3};
        vecs[3]  = '{2'd3, 7'd5,   3'd0, 3'd3, 3'd3};
        vecs[4]  = '{2'd2, 7'd127, 3'd6, 3'd0, 3'd6};
        vecs[5]  = '{2'd0, 7'd127, 3'd0, 3'd6, 3'd7};
        vecs[6]  = '{2'd0, 7'd127, 3'd0, 3'd7, 3'd7};
        vecs[7]  = '{2'd1, 7'd0,   3'd0, 3'd0, 3'd0};
        vecs[8]  = '{2'd1, 7'd5,   3'd0, 3'd3, 3'd2};
        vecs[9]  = '{2'd2, 7'd20,  3'd5, 3'd0, 3'd5};
        vecs[10] = '{2'd2, 7'd5,   3'd0, 3'd2, 3'd0};
        vecs[11] = '{2'd0, 7'd20,  3'd0, 3'd5, 3'd6};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_ready", int'(UpdReady), 0);
        check("rst_rsp_valid", int'(RspValid), 0);
        check("rst_wen", int'(CtrWen), 0);
        check("rst_atten", int'(CtrAtten), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_addr", int'(CtrAddr), 0);
        Rest = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_upd(vecs[i].op, vecs[i].addr, vecs[i].val, o, n, ra, lat, ok);
            check($sformatf("vec%0d_done", i), int'(ok), 1);
            check($sformatf("vec%0d_lat", i), lat, 2);
            check($sformatf("vec%0d_addr", i), int'(ra), int'(vecs[i].addr));
            check($sformatf("vec%0d_old", i), int'(o), int'(vecs[i].exp_old));
            check($sformatf("vec%0d_new", i), int'(n), int'(vecs[i].exp_new));
        end
        check("table_127", int'(mem[127]), 7);

        for (int i = 0; i < 9; i++) begin
            step(1'b1, 2'd3, 7'd127, 3'd0, 1'b0);
            check($sformatf("cadence%0d", i), int'(UpdReady), int'(i % 3 == 0));
            if (i % 3 == 2) check("cadence_new", int'(RspNew), 7);
        end

        step(1'b1, 2'd0, 7'd20, 3'd0, 1'b1);
        check("agefirst_ready", int'(UpdReady), 0);
        step(1'b1, 2'd0, 7'd20, 3'd0, 1'b0);
        check("agefirst_atten", int'(CtrAtten), 1);
        check("agefirst_ready_in_age", int'(UpdReady), 0);
        step(1'b1, 2'd0, 7'd20, 3'd0, 1'b0);
        check("agefirst_accept", int'(UpdReady), 1);
        step(1'b0, 2'd0, 7'd0, 3'd0, 1'b0);
        check("agefirst_read_atten", int'(CtrAtten), 0);
        step(1'b0, 2'd0, 7'd0, 3'd0, 1'b0);
        check("agefirst_rsp", int'(RspValid), 1);
        check("agefirst_old", int'(RspOld), 5);
        check("agefirst_new", int'(RspNew), 6);

        step(1'b1, 2'd3, 7'd127, 3'd0, 1'b0);
        check("midage_accept", int'(UpdReady), 1);
        step(1'b0, 2'd0, 7'd0, 3'd0, 1'b1);
        check("midage_read_atten", int'(CtrAtten), 0);
        step(1'b0, 2'd0, 7'd0, 3'd0, 1'b1);
        check("midage_write_rsp", int'(RspValid), 1);
        check("midage_write_atten", int'(CtrAtten), 0);
        check("midage_old", int'(RspOld), 6);
        pulses  = 0;
        first_i = -1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'd0, 7'd0, 3'd0, 1'b0);
            if (CtrAtten) begin
                pulses++;
                if (first_i < 0) first_i = i;
            end
        end
        check("midage_pulses", pulses, 1);
        check("midage_when", first_i, 1);

        step(1'b1, 2'd2, 7'd5, 3'd7, 1'b0);
        check("rstmid_accept", int'(UpdReady), 1);
        @(posedge Clk);
        #1;
        UpdValid = 1'b0;
        check("rstmid_read_addr", int'(CtrAddr), 5);
        Rest = 1'b0;
        #1;
        check("rstmid_addr_cleared", int'(CtrAddr), 0);
        mism = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            mism += int'(CtrWen) + int'(RspValid) + int'(UpdReady) + int'(CtrAtten);
        end
        check("rstmid_quiet", mism, 0);
        pre16_addr = 7'd9;
        pre16_val  = 3'd2;
        pre16_en   = 1'b1;
        Rest       = 1'b1;

        for (int i = 0; i < 60; i++) begin
            @(posedge Clk);
            #1;
            pre16_en = 1'b0;
            @(negedge Clk);
            if (i == 0) begin
                check("rel_ready", int'(UpdReady), 1);
                check("rel_busy", int'(Busy), 0);
            end
            check("p16_atten", int'(u16_atten), int'(ecnt % 16 == 0 && ecnt != 0));
            check("main_atten_idle", int'(CtrAtten), 0);
            if (ecnt == 10) check("p16_entry_preset", int'(mem16[9]), 2);
            if (ecnt == 20) check("p16_entry_1", int'(mem16[9]), 1);
            if (ecnt == 36) check("p16_entry_2", int'(mem16[9]), 0);
            if (ecnt == 52) check("p16_entry_3", int'(mem16[9]), 0);
        end

        for (int i = 0; i < 128; i++) mdl_mem[i] = 3'd0;
        for (int i = 0; i < 2600; i++) rnd_iter(1'b1);
        for (int i = 0; i < 8; i++) rnd_iter(1'b0);
        check("rnd_drained", pq.size(), 0);
        mism = 0;
        for (int i = 0; i < 128; i++)
            if (mem[i] !== mdl_mem[i]) mism++;
        check("rnd_table_final", mism, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/useful_ctr_ctrl.md
Name: useful_ctr_ctrl

Overview:
- Update controller that drives the 128-entry 3-bit saturating counter table, which has a 1-cycle registered read, a single port, and a global decrement (Atten).
- Accepts increment, decrement and set requests from the predictor update stage and performs read-modify-write on the table.
- Schedules periodic and on-demand aging pulses on the table's Atten input.

Parameters:
- AGE_PERIOD, 1024, cycles between automatic aging requests (must be ≥2).
- AGE_W, 10, width of the age timer; must hold AGE_PERIOD-1.

Ports:
- Clk  in  1  clock.
- Rest  in  1  asynchronous active-low reset.
- UpdValid  in  1  update request valid.
- UpdReady  out  1  controller can accept an update this cycle.
- UpdAddr  in  7  table index.
- UpdOp  in  2  operation: 00 inc, 01 dec, 10 set, 11 reserved (treated as no-op write-back of the old value).
- UpdVal  in  3  value for set.
- AgeReq  in  1  external aging request; sticky until serviced.
- RspValid  out  1  one-cycle pulse when the write-back completes.
- RspAddr  out  7  index that was written.
- RspOld  out  3  value read before the update.
- RspNew  out  3  value written.
- CtrAtten  out  1  to table Atten.
- CtrAddr  out  7  to table Addr.
- CtrWen  out  1  to table Wen.
- CtrDin  out  3  to table Din.
- CtrDout  in  3  from table Dout; valid the cycle after a read cycle.
- Busy  out  1  state is not IDLE, or an age request is pending.

Behaviour:
- Reset (async, Rest=0):
  - State = IDLE; age timer = 0; AgePend = 0; latched address/op/value = 0.
  - All outputs 0 except UpdReady = 0 while Rest is low.
  - Table reset is synchronous to Clk. The controller holds CtrWen = 0 and CtrAtten = 0 throughout reset.
- All Ctr* and Rsp* outputs are decoded from registers only. There is no combinational path from Upd*/AgeReq to any output except UpdReady.
- FSM states: IDLE, READ, WRITE, AGE.
- IDLE:
  - If AgePend = 1, go to AGE. Aging has priority over a waiting update, and UpdReady = 0 in this case.
  - Otherwise UpdReady = 1. On UpdValid, latch UpdAddr/UpdOp/UpdVal and go to READ.
- READ (1 cycle):
  - CtrAddr = latched address, CtrWen = 0, CtrAtten = 0.
  - Go to WRITE.
- WRITE (1 cycle):
  - CtrDout holds the old value. CtrAddr = latched address, CtrWen = 1.
  - CtrDin: inc = min(old+1, 7); dec = max(old-1, 0); set = UpdVal; reserved = old.
  - RspValid = 1, with RspOld = old, RspNew = CtrDin, RspAddr = latched address.
  - Go to IDLE.
- AGE (1 cycle):
  - CtrAtten = 1, CtrWen = 0, CtrAddr = 0.
  - Clear AgePend, unless AgeReq is high this same cycle; that new request re-arms AgePend.
  - Go to IDLE.
- Throughput: one update per 3 cycles (IDLE accept, READ, WRITE). The latency from accept to RspValid is 2 cycles.
- Single port: READ and WRITE of the same update are never overlapped with another access, so no read/write hazard exists.
- Age timer:
  - Free-running, 0..AGE_PERIOD-1, increments every cycle out of reset.
  - On wrap it sets AgePend.
  - AgeReq=1 in any cycle sets AgePend.
  - Multiple requests collapse into a single pending pulse.
  - A wrap while in AGE re-arms AgePend.
- Aging is never issued between READ and WRITE. A pending age waits until WRITE completes.
- Reset mid-operation (READ or WRITE) aborts the update with no write and no RspValid. The request is lost; the requester must reissue.
- Reserved op 11 still consumes a full RMW and pulses RspValid with RspNew = RspOld.

Test Plan:
- Reset, then inc addr 5 three times → RspOld 0,1,2 and RspNew 1,2,3. A subsequent read of the table entry returns 3. UpdReady is high one cycle in every three.
- Set addr 127 to 6, then inc twice → RspNew 7 then 7 (saturation). Dec on addr 0 while it holds 0 → RspNew 0.
- AGE_PERIOD=16, with no updates → CtrAtten pulses at cycle 16 after reset and every 16 cycles thereafter. A table entry preset to 2 reads 1, then 0, then stays 0.
- AgeReq asserted in the same cycle UpdValid arrives in IDLE → AGE occurs first (CtrAtten=1, UpdReady=0), then the update is accepted the next cycle. RspOld reflects the aged value.
- AgeReq asserted during READ → CtrAtten is not asserted until after WRITE. Exactly one Atten pulse occurs, even if AgeReq is held high for 2 cycles before service.
- Rest dropped during READ → no CtrWen pulse and no RspValid. After release, state is IDLE, UpdReady=1, and the age timer restarts from 0.
